skeleton_echo_buffer: RTL and testbench

//  Successor of the single-word echo skeleton: multi-word buffered test skeleton for on-device

---
 rtl/skeleton_echo_buffer.sv | 136 +++++++++++++
 tb/tb_skeleton_echo_buffer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/skeleton_echo_buffer.sv
// Multi-word test skeleton: host fills the input buffer, triggers, and reads back echo/reverse/increment results.
// Latency: NUM_WORDS cycles per calculation, 1-cycle registered reads; no backpressure, writes/triggers during CALC are dropped.
module skeleton_echo_buffer #(
    parameter int BITWIDTH_DATA = 16,
    parameter int NUM_WORDS     = 8,
    parameter int BITWIDTH_ADDR = 3,
    parameter int MODE          = 0,
    parameter int BITWIDTH_HEAD = 26
) (
    input  logic                     CLK_SYS,
    input  logic                     RST,
    input  logic                     EN,
    input  logic                     WR_EN,
    input  logic [BITWIDTH_ADDR-1:0] WR_ADDR,
    input  logic [BITWIDTH_DATA-1:0] DATA_IN,
    input  logic                     TRGG_START_CALC,
    input  logic [BITWIDTH_ADDR-1:0] RD_ADDR,
    output logic [BITWIDTH_DATA-1:0] DATA_OUT,
    output logic [BITWIDTH_HEAD-1:0] DATA_HEAD,
    output logic                     DATA_VALID,
    output logic                     BUSY
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [BITWIDTH_ADDR-1:0] LAST_IDX = BITWIDTH_ADDR'(NUM_WORDS - 1);

    state_t                   state_q, state_d;
    logic [BITWIDTH_ADDR-1:0] cnt_q, cnt_d;
    logic                     done_q, done_d;
    logic [BITWIDTH_DATA-1:0] in_q  [NUM_WORDS];
    logic [BITWIDTH_DATA-1:0] in_d  [NUM_WORDS];
    logic [BITWIDTH_DATA-1:0] out_q [NUM_WORDS];
    logic [BITWIDTH_DATA-1:0] out_d [NUM_WORDS];
    logic [BITWIDTH_DATA-1:0] dout_q, dout_d;

    logic [BITWIDTH_ADDR-1:0] src_idx;
    logic [BITWIDTH_DATA-1:0] src_word;
    logic [BITWIDTH_DATA-1:0] calc_word;
    logic                     sync_rst;

    assign sync_rst = RST | ~EN;

    always_comb begin
        src_idx = (MODE == 1) ? (LAST_IDX - cnt_q) : cnt_q;
        src_word = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (src_idx == BITWIDTH_ADDR'(i)) begin
                src_word = in_q[i];
            end
        end
        // Increment mode wraps silently at the data width.
        calc_word = (MODE == 2) ? (src_word + BITWIDTH_DATA'(1)) : src_word;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        in_d    = in_q;
        out_d   = out_q;

        case (state_q)
            IDLE, DONE: begin
                for (int i = 0; i < NUM_WORDS; i++) begin
                    if (WR_EN && (WR_ADDR == BITWIDTH_ADDR'(i))) begin
                        in_d[i] = DATA_IN;
                    end
                end
                if (TRGG_START_CALC) begin
                    state_d = CALC;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                end
            end
            CALC: begin
                for (int i = 0; i < NUM_WORDS; i++) begin
                    if (cnt_q == BITWIDTH_ADDR'(i)) begin
                        out_d[i] = calc_word;
                    end
                end
                cnt_d = cnt_q + BITWIDTH_ADDR'(1);
                if (cnt_q == LAST_IDX) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        dout_d = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (RD_ADDR == BITWIDTH_ADDR'(i)) begin
                dout_d = out_q[i];
            end
        end
    end

    always_ff @(posedge CLK_SYS) begin
        if (sync_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            dout_q  <= '0;
            for (int i = 0; i < NUM_WORDS; i++) begin
                in_q[i]  <= '0;
                out_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            dout_q  <= dout_d;
            for (int i = 0; i < NUM_WORDS; i++) begin
                in_q[i]  <= in_d[i];
                out_q[i] <= out_d[i];
            end
        end
    end

    assign DATA_OUT   = dout_q;
    assign BUSY       = (state_q == CALC);
    assign DATA_VALID = done_q & (state_q != CALC) & ~TRGG_START_CALC;
    assign DATA_HEAD  = BITWIDTH_HEAD'({4'(MODE + 1), 6'(NUM_WORDS), 6'(NUM_WORDS),
                                        5'(BITWIDTH_DATA), 5'(BITWIDTH_DATA)});

endmodule

// File: tb/tb_skeleton_echo_buffer.sv
// Bench for skeleton_echo_buffer: echo, reverse, increment and a 6-word instance share one stimulus.
module tb_skeleton_echo_buffer;

    logic        clk = 1'b0;
    logic        rst, en, wr_en, trg;
    logic [2:0]  wr_addr, rd_addr;
    logic [15:0] din;
    logic [15:0] dout  [4];
    logic [25:0] head  [4];
    logic        valid [4];
    logic        busy  [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    skeleton_echo_buffer #(.MODE(0)) dut0 (
        .CLK_SYS(clk), .RST(rst), .EN(en), .WR_EN(wr_en), .WR_ADDR(wr_addr), .DATA_IN(din),
        .TRGG_START_CALC(trg), .RD_ADDR(rd_addr), .DATA_OUT(dout[0]), .DATA_HEAD(head[0]),
        .DATA_VALID(valid[0]), .BUSY(busy[0]));
    skeleton_echo_buffer #(.MODE(1)) dut1 (
        .CLK_SYS(clk), .RST(rst), .EN(en), .WR_EN(wr_en), .WR_ADDR(wr_addr), .DATA_IN(din),
        .TRGG_START_CALC(trg), .RD_ADDR(rd_addr), .DATA_OUT(dout[1]), .DATA_HEAD(head[1]),
        .DATA_VALID(valid[1]), .BUSY(busy[1]));
    skeleton_echo_buffer #(.MODE(2)) dut2 (
        .CLK_SYS(clk), .RST(rst), .EN(en), .WR_EN(wr_en), .WR_ADDR(wr_addr), .DATA_IN(din),
        .TRGG_START_CALC(trg), .RD_ADDR(rd_addr), .DATA_OUT(dout[2]), .DATA_HEAD(head[2]),
        .DATA_VALID(valid[2]), .BUSY(busy[2]));
    // Six words on a 3-bit address makes addresses 6 and 7 out of range.
    skeleton_echo_buffer #(.MODE(0), .NUM_WORDS(6)) dut3 (
        .CLK_SYS(clk), .RST(rst), .EN(en), .WR_EN(wr_en), .WR_ADDR(wr_addr), .DATA_IN(din),
        .TRGG_START_CALC(trg), .RD_ADDR(rd_addr), .DATA_OUT(dout[3]), .DATA_HEAD(head[3]),
        .DATA_VALID(valid[3]), .BUSY(busy[3]));

    typedef struct packed {
        logic             rst;
        logic             wr_en;
        logic [2:0]       wr_addr;
        logic [15:0]      din;
        logic             trg;
        logic [2:0]       rd_addr;
        logic             exp_busy;
        logic             exp_valid;
        logic [3:0]       chk;
        logic [3:0][15:0] exp_dout;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic w, logic [2:0] wa, logic [15:0] d, logic t,
                                logic [2:0] ra, logic b, logic v, logic [3:0] c,
                                logic [15:0] e0, logic [15:0] e1, logic [15:0] e2, logic [15:0] e3);
        vec_t x;
        x.rst = r; x.wr_en = w; x.wr_addr = wa; x.din = d; x.trg = t; x.rd_addr = ra;
        x.exp_busy = b; x.exp_valid = v; x.chk = c;
        x.exp_dout[0] = e0; x.exp_dout[1] = e1; x.exp_dout[2] = e2; x.exp_dout[3] = e3;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [2:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; din = d;
        tick();
        wr_en = 1'b0;
    endtask

    // Abort a calculation four cycles in, by RST or by EN, and confirm nothing survives.
    task automatic reset_mid_calc(input logic use_en);
        for (int k = 0; k < 8; k++) write_word(3'(k), 16'h1000 + 16'(k));
        rd_addr = 3'd0;
        trg = 1'b1;
        tick();
        trg = 1'b0;
        repeat (3) tick();
        check("abort_busy_before", 32'(busy[0]), 32'd1);
        check("abort_partial_read", 32'(dout[0]), 32'h1000);
        if (use_en) en = 1'b0;
        else rst = 1'b1;
        tick();
        check("abort_busy", 32'(busy[0]), 32'd0);
        check("abort_valid", 32'(valid[0]), 32'd0);
        check("abort_dout", 32'(dout[0]), 32'd0);
        check("abort_dout_mode2", 32'(dout[2]), 32'd0);
        rst = 1'b0;
        en  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            rd_addr = 3'(k);
            tick();
            check("abort_out_mode0", 32'(dout[0]), 32'd0);
            check("abort_out_mode1", 32'(dout[1]), 32'd0);
            check("abort_valid_after", 32'(valid[0]), 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        logic [15:0] w;
        rst = 1'b1; en = 1'b1; wr_en = 1'b0; trg = 1'b0;
        wr_addr = '0; rd_addr = '0; din = '0;

        // Reset, load 0x1000+k, trigger, run 8 calc edges, then read every address.
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 4'hF, 0, 0, 0, 0));
        for (int k = 0; k < 8; k++) begin
            w = 16'h1000 + 16'(k);
            vecs.push_back(mk(0, 1, 3'(k), w, 0, 0, 0, 0, 4'hF, 0, 0, 0, 0));
        end
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 4'hF, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 4'hF, 0, 0, 0, 0));
        for (int i = 2; i <= 8; i++) begin
            vecs.push_back(mk(0, 0, 0, 0, 0, 0, (i < 8), (i == 8), 4'hF,
                              16'h1000, 16'h1007, 16'h1001, 16'h1000));
        end
        for (int k = 0; k < 8; k++) begin
            vecs.push_back(mk(0, 0, 0, 0, 0, 3'(k), 0, 1, 4'hF,
                              16'h1000 + 16'(k), 16'h1007 - 16'(k), 16'h1001 + 16'(k),
                              (k < 6) ? 16'h1000 + 16'(k) : 16'h0000));
        end

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; wr_en = vecs[i].wr_en; wr_addr = vecs[i].wr_addr;
            din = vecs[i].din; trg = vecs[i].trg; rd_addr = vecs[i].rd_addr;
            tick();
            check($sformatf("vec%0d_busy", i), 32'(busy[0]), 32'(vecs[i].exp_busy));
            check($sformatf("vec%0d_valid", i), 32'(valid[0]), 32'(vecs[i].exp_valid));
            for (int d = 0; d < 4; d++) begin
                if (vecs[i].chk[d])
                    check($sformatf("vec%0d_dout%0d", i, d), 32'(dout[d]), 32'(vecs[i].exp_dout[d]));
            end
        end
        wr_en = 1'b0; trg = 1'b0; rst = 1'b0;

        check("head_mode0", 32'(head[0]), 32'({4'd1, 6'd8, 6'd8, 5'd16, 5'd16}));
        check("head_mode1", 32'(head[1]), 32'({4'd2, 6'd8, 6'd8, 5'd16, 5'd16}));
        check("head_mode2", 32'(head[2]), 32'({4'd3, 6'd8, 6'd8, 5'd16, 5'd16}));
        check("head_words6", 32'(head[3]), 32'({4'd1, 6'd6, 6'd6, 5'd16, 5'd16}));

        // Writes in DONE keep the result valid and leave the out buffer alone; then increment wraps.
        rd_addr = 3'd0;
        write_word(3'd0, 16'hFFFF);
        check("done_write_valid", 32'(valid[0]), 32'd1);
        check("done_write_out_kept", 32'(dout[0]), 32'h1000);
        write_word(3'd1, 16'h0041);
        trg = 1'b1;
        tick();
        trg = 1'b0;
        repeat (8) tick();
        rd_addr = 3'd0;
        tick();
        check("wrap_out0_mode2", 32'(dout[2]), 32'h0000);
        check("wrap_out0_mode0", 32'(dout[0]), 32'hFFFF);
        rd_addr = 3'd1;
        tick();
        check("wrap_out1_mode2", 32'(dout[2]), 32'h0042);
        check("wrap_out1_mode0", 32'(dout[0]), 32'h0041);
        check("wrap_out1_mode1", 32'(dout[1]), 32'h1006);

        // Trigger and write pulsed mid-calculation must be ignored.
        trg = 1'b1;
        tick();
        trg = 1'b0;
        n = 0;
        for (int i = 0; i < 20 && busy[0]; i++) begin
            n++;
            if (i == 2) begin
                trg = 1'b1; wr_en = 1'b1; wr_addr = 3'd2; din = 16'hDEAD;
            end else begin
                trg = 1'b0; wr_en = 1'b0;
            end
            tick();
        end
        trg = 1'b0; wr_en = 1'b0;
        check("busy_len_with_retrigger", 32'(n), 32'd8);
        check("valid_after_calc", 32'(valid[0]), 32'd1);
        trg = 1'b1;
        #2;
        check("valid_masked_by_trigger", 32'(valid[0]), 32'd0);
        trg = 1'b0;
        #2;
        check("valid_after_trigger_drop", 32'(valid[0]), 32'd1);
        rd_addr = 3'd2;
        tick();
        check("calc_write_ignored", 32'(dout[0]), 32'h1002);
        check("calc_write_ignored_mode1", 32'(dout[1]), 32'h1005);
        check("calc_write_ignored_mode2", 32'(dout[2]), 32'h1003);

        reset_mid_calc(1'b0);
        reset_mid_calc(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
